// File: rtl/mem_hazard_ctrl_if.sv
// mem_hazard_ctrl_if: pipeline fields seen by the hazard controller and the hold/flush/redirect controls it returns.
// Latency: none (wires only).
// Backpressure: o_dmem_req stays high until i_dmem_ack; no other flow control.
// Modports:
//   master - datapath side: drives the EX/MEM, ID/EX and ID fields plus i_dmem_ack, receives the controls
//   slave  - mem_hazard_ctrl: receives the fields, drives every o_* control
interface mem_hazard_ctrl_if #(
  parameter int CNT_W = 8
);
  // EX/MEM pipeline register outputs
  logic             i_MEM_ctrl_MemRead;
  logic             i_MEM_ctrl_MemWrite;
  logic             i_MEM_ctrl_Branch;
  logic             i_MEM_data_Zero;
  logic             i_MEM_data_Overflow;
  // ID/EX load destination
  logic             i_EX_ctrl_MemRead;
  logic [4:0]       i_EX_data_RegAddrW;
  // ID-stage source registers
  logic [4:0]       i_ID_data_RS;
  logic [4:0]       i_ID_data_RT;
  // data memory handshake
  logic             i_dmem_ack;
  logic             o_dmem_req;
  // register holds
  logic             o_PC_hold;
  logic             o_IF_ID_hold;
  logic             o_ID_EX_hold;
  logic             o_EX_MEM_hold;
  // register bubbles
  logic             o_IF_ID_flush;
  logic             o_ID_EX_flush;
  logic             o_EX_MEM_flush;
  logic             o_MEM_WB_flush;
  // redirects and status
  logic             o_PCSrc;
  logic             o_exc_take;
  logic             o_dmem_err;
  logic [CNT_W-1:0] o_exc_count;

  modport master (
    output i_MEM_ctrl_MemRead, i_MEM_ctrl_MemWrite, i_MEM_ctrl_Branch,
           i_MEM_data_Zero, i_MEM_data_Overflow,
           i_EX_ctrl_MemRead, i_EX_data_RegAddrW,
           i_ID_data_RS, i_ID_data_RT, i_dmem_ack,
    input  o_dmem_req,
           o_PC_hold, o_IF_ID_hold, o_ID_EX_hold, o_EX_MEM_hold,
           o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_MEM_WB_flush,
           o_PCSrc, o_exc_take, o_dmem_err, o_exc_count
  );

  modport slave (
    input  i_MEM_ctrl_MemRead, i_MEM_ctrl_MemWrite, i_MEM_ctrl_Branch,
           i_MEM_data_Zero, i_MEM_data_Overflow,
           i_EX_ctrl_MemRead, i_EX_data_RegAddrW,
           i_ID_data_RS, i_ID_data_RT, i_dmem_ack,
    output o_dmem_req,
           o_PC_hold, o_IF_ID_hold, o_ID_EX_hold, o_EX_MEM_hold,
           o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_MEM_WB_flush,
           o_PCSrc, o_exc_take, o_dmem_err, o_exc_count
  );
endinterface

// File: rtl/mem_hazard_ctrl.sv
// mem_hazard_ctrl: sole stall/flush source for the 5-stage MIPS pipeline (exception, branch, dmem wait, load-use).
// Latency: controls are combinational from inputs and state; only state, wait counter and o_exc_count are registered.
// Backpressure: an unacknowledged dmem access freezes PC..EX/MEM and bubbles MEM/WB until i_dmem_ack.
// Ports: clk, rst (async active-high), bus (mem_hazard_ctrl_if.slave: pipeline fields in, hold/flush/redirect out).
// Optional macro MEM_HAZARD_CTRL_TIMEOUT_EN adds a watchdog that aborts a wait after TIMEOUT cycles (o_dmem_err).
module mem_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] exc_cnt;

  logic access;
  logic taken;
  logic load_use;
  logic timeout_hit;

  logic dmem_req;
  logic pc_hold;
  logic if_id_hold;
  logic id_ex_hold;
  logic ex_mem_hold;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic pc_src;
  logic exc_take;
  logic dmem_err;

  // An overflowing instruction never reaches memory, even when it is a load/store.
  assign access = (bus.i_MEM_ctrl_MemRead | bus.i_MEM_ctrl_MemWrite) & ~bus.i_MEM_data_Overflow;
  assign taken  = bus.i_MEM_ctrl_Branch & bus.i_MEM_data_Zero;

  // $0 is never a real dependency, so a load targeting it never interlocks.
  assign load_use = bus.i_EX_ctrl_MemRead
                  & (bus.i_EX_data_RegAddrW != 5'd0)
                  & ((bus.i_EX_data_RegAddrW == bus.i_ID_data_RS) |
                     (bus.i_EX_data_RegAddrW == bus.i_ID_data_RT));

`ifdef MEM_HAZARD_CTRL_TIMEOUT_EN
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  // wait_cnt counts completed MEM_WAIT cycles without ack; the watchdog
  // fires in the cycle whose miss would bring that count to TIMEOUT, so
  // with TIMEOUT=N the abort lands on the (N+1)-th request cycle.
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == MEM_WAIT) && !bus.i_dmem_ack &&
                       (({1'b0, wait_cnt} + 9'd1) == TO_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (state == RUN && state_nxt == MEM_WAIT) begin
      wait_cnt <= 8'd0;
    end else if (state == MEM_WAIT && !bus.i_dmem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  // Watchdog compiled out: TIMEOUT < 0 is never true, so a wait lasts until ack.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_nxt    = state;
    dmem_req     = 1'b0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_src       = 1'b0;
    exc_take     = 1'b0;
    dmem_err     = 1'b0;

    unique case (state)
      RUN: begin
        if (bus.i_MEM_data_Overflow) begin
          // Bubble everything including MEM/WB so the faulting op never writes back.
          exc_take     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          mem_wb_flush = 1'b1;
        end else if (taken) begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (access && !bus.i_dmem_ack) begin
          dmem_req     = 1'b1;
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_hold   = 1'b1;
          ex_mem_hold  = 1'b1;
          mem_wb_flush = 1'b1;
          state_nxt    = MEM_WAIT;
        end else begin
          // A zero-wait access does not stall, so a load-use hazard
          // behind it must still interlock in the same cycle.
          dmem_req = access;
          if (load_use) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
      end

      MEM_WAIT: begin
        if (bus.i_dmem_ack) begin
          // Ack beats the watchdog: the access completes normally.
          dmem_req  = 1'b1;
          state_nxt = RUN;
        end else if (timeout_hit) begin
          // Abort: request drops, the stuck access is squashed like an exception.
          dmem_err     = 1'b1;
          exc_take     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          mem_wb_flush = 1'b1;
          state_nxt    = RUN;
        end else begin
          dmem_req     = 1'b1;
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_hold   = 1'b1;
          ex_mem_hold  = 1'b1;
          mem_wb_flush = 1'b1;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      exc_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (exc_take && (exc_cnt != '1)) begin
        exc_cnt <= exc_cnt + CNT_ONE;
      end
    end
  end

  // Reset forces every combinational control low so the datapath sees
  // no request or redirect while rst is high, independent of the clock.
  assign bus.o_dmem_req     = dmem_req     & ~rst;
  assign bus.o_PC_hold      = pc_hold      & ~rst;
  assign bus.o_IF_ID_hold   = if_id_hold   & ~rst;
  assign bus.o_ID_EX_hold   = id_ex_hold   & ~rst;
  assign bus.o_EX_MEM_hold  = ex_mem_hold  & ~rst;
  assign bus.o_IF_ID_flush  = if_id_flush  & ~rst;
  assign bus.o_ID_EX_flush  = id_ex_flush  & ~rst;
  assign bus.o_EX_MEM_flush = ex_mem_flush & ~rst;
  assign bus.o_MEM_WB_flush = mem_wb_flush & ~rst;
  assign bus.o_PCSrc        = pc_src       & ~rst;
  assign bus.o_exc_take     = exc_take     & ~rst;
  assign bus.o_dmem_err     = dmem_err     & ~rst;
  assign bus.o_exc_count    = exc_cnt;

  // A register is either held or bubbled, never both.
  a_if_id_excl:  assert property (@(posedge clk) disable iff (rst)
                   !(bus.o_IF_ID_hold && bus.o_IF_ID_flush));
  a_id_ex_excl:  assert property (@(posedge clk) disable iff (rst)
                   !(bus.o_ID_EX_hold && bus.o_ID_EX_flush));
  a_ex_mem_excl: assert property (@(posedge clk) disable iff (rst)
                   !(bus.o_EX_MEM_hold && bus.o_EX_MEM_flush));

endmodule

// File: tb/tb_mem_hazard_ctrl.sv
// tb_mem_hazard_ctrl: self-checking bench for mem_hazard_ctrl.
// Latency: outputs sampled 2 time units after the falling edge, inputs driven on the falling edge.
// Backpressure: the bench plays the data memory, choosing when i_dmem_ack rises.
module tb_mem_hazard_ctrl;

  localparam int TO = 4;

  // Output vector layout: {err, exc, pcsrc, req, hold PC/IFID/IDEX/EXMEM, flush IFID/IDEX/EXMEM/MEMWB}
  localparam logic [11:0] O_IDLE   = 12'h000;
  localparam logic [11:0] O_REQ    = 12'h100;
  localparam logic [11:0] O_FRZ    = 12'h1F1;
  localparam logic [11:0] O_EXC    = 12'h40F;
  localparam logic [11:0] O_BR     = 12'h20E;
  localparam logic [11:0] O_LU     = 12'h0C4;
  localparam logic [11:0] O_REQ_LU = 12'h1C4;
  localparam logic [11:0] O_TO     = 12'hC0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_hazard_ctrl_if #(.CNT_W(8)) bus ();
  mem_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_wait, m_nwait, m_exc;
  int m_waited, m_nwaited;
  int m_cnt = 0;

  typedef struct {
    logic       mr, mw, br, zero, ovf, exmr;
    logic [4:0] rd, rs, rt;
    logic       ack;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic mr, mw, br, zero, ovf, exmr,
                              input logic [4:0] rd, rs, rt,
                              input logic ack, input logic [11:0] exp);
    vec_t v;
    v.mr = mr; v.mw = mw; v.br = br; v.zero = zero; v.ovf = ovf; v.exmr = exmr;
    v.rd = rd; v.rs = rs; v.rt = rt; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] dut_out();
    return {bus.o_dmem_err, bus.o_exc_take, bus.o_PCSrc, bus.o_dmem_req,
            bus.o_PC_hold, bus.o_IF_ID_hold, bus.o_ID_EX_hold, bus.o_EX_MEM_hold,
            bus.o_IF_ID_flush, bus.o_ID_EX_flush, bus.o_EX_MEM_flush, bus.o_MEM_WB_flush};
  endfunction

  task automatic drive(input logic mr, mw, br, zero, ovf, exmr,
                       input logic [4:0] rd, rs, rt, input logic ack);
    bus.i_MEM_ctrl_MemRead  = mr;
    bus.i_MEM_ctrl_MemWrite = mw;
    bus.i_MEM_ctrl_Branch   = br;
    bus.i_MEM_data_Zero     = zero;
    bus.i_MEM_data_Overflow = ovf;
    bus.i_EX_ctrl_MemRead   = exmr;
    bus.i_EX_data_RegAddrW  = rd;
    bus.i_ID_data_RS        = rs;
    bus.i_ID_data_RT        = rt;
    bus.i_dmem_ack          = ack;
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  // Behavioural reference: the rules stated in priority order, producing
  // the expected control vector and the model's next wait bookkeeping.
  task automatic model_eval(output logic [11:0] e);
    bit acc, tk, lu, ovf, ack, to_hit;
    ovf = bus.i_MEM_data_Overflow;
    ack = bus.i_dmem_ack;
    acc = (bus.i_MEM_ctrl_MemRead || bus.i_MEM_ctrl_MemWrite) && !ovf;
    tk  = bus.i_MEM_ctrl_Branch && bus.i_MEM_data_Zero;
    lu  = bus.i_EX_ctrl_MemRead && (bus.i_EX_data_RegAddrW != 0) &&
          (bus.i_EX_data_RegAddrW == bus.i_ID_data_RS ||
           bus.i_EX_data_RegAddrW == bus.i_ID_data_RT);
    e = O_IDLE;
    m_nwait = m_wait;
    m_nwaited = m_waited;
    m_exc = 1'b0;
    to_hit = 1'b0;
    if (!m_wait) begin
      if (ovf) begin
        e = O_EXC; m_exc = 1'b1;
      end else if (tk) begin
        e = O_BR;
      end else if (acc && !ack) begin
        e = O_FRZ; m_nwait = 1'b1; m_nwaited = 0;
      end else begin
        if (lu)  e = O_LU;
        if (acc) e = e | O_REQ;
      end
    end else begin
`ifdef MEM_HAZARD_CTRL_TIMEOUT_EN
      to_hit = !ack && (m_waited + 1 == TO);
`endif
      if (ack) begin
        e = O_REQ; m_nwait = 1'b0;
      end else if (to_hit) begin
        e = O_TO; m_exc = 1'b1; m_nwait = 1'b0;
      end else begin
        e = O_FRZ; m_nwaited = m_waited + 1;
      end
    end
  endtask

  task automatic model_commit();
    m_wait = m_nwait;
    m_waited = m_nwaited;
    if (m_exc) m_cnt = sat_inc(m_cnt);
  endtask

  initial begin
    vec_t tbl[18];
    logic [11:0] e;

    tbl[0]  = mk(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0, O_IDLE);
    tbl[1]  = mk(1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 1, O_REQ);
    tbl[2]  = mk(0,1,0,0,0,0, 5'd0, 5'd0, 5'd0, 1, O_REQ);
    tbl[3]  = mk(1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0, O_FRZ);
    tbl[4]  = mk(0,0,1,1,0,0, 5'd0, 5'd0, 5'd0, 0, O_BR);
    tbl[5]  = mk(0,0,1,0,0,0, 5'd0, 5'd0, 5'd0, 0, O_IDLE);
    tbl[6]  = mk(0,1,0,0,1,0, 5'd0, 5'd0, 5'd0, 0, O_EXC);
    tbl[7]  = mk(0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 1, O_EXC);
    tbl[8]  = mk(0,0,0,0,0,1, 5'd5, 5'd5, 5'd0, 0, O_LU);
    tbl[9]  = mk(0,0,0,0,0,1, 5'd9, 5'd3, 5'd9, 0, O_LU);
    tbl[10] = mk(0,0,0,0,0,1, 5'd0, 5'd0, 5'd0, 0, O_IDLE);
    tbl[11] = mk(0,0,0,0,0,1, 5'd5, 5'd6, 5'd7, 0, O_IDLE);
    tbl[12] = mk(0,0,1,1,0,1, 5'd5, 5'd5, 5'd5, 0, O_BR);
    tbl[13] = mk(1,0,0,0,0,1, 5'd5, 5'd5, 5'd0, 1, O_REQ_LU);
    tbl[14] = mk(0,0,1,1,1,0, 5'd0, 5'd0, 5'd0, 0, O_EXC);
    tbl[15] = mk(0,0,0,0,0,0, 5'd5, 5'd5, 5'd5, 0, O_IDLE);
    tbl[16] = mk(1,0,0,0,0,1, 5'd5, 5'd5, 5'd0, 0, O_FRZ);
    tbl[17] = mk(1,1,0,0,1,1, 5'd5, 5'd5, 5'd5, 1, O_EXC);

    // Reset: live inputs must not leak through while rst is high.
    drive(1,0,0,0,1,1, 5'd5, 5'd5, 5'd5, 0);
    #2;
    chk12("reset_outs", dut_out(), O_IDLE);
    chk8("reset_cnt", bus.o_exc_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);

    // Single-cycle behaviour from RUN; each vector is followed by an ack
    // cycle so a vector that entered MEM_WAIT returns to RUN.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].mr, tbl[i].mw, tbl[i].br, tbl[i].zero, tbl[i].ovf, tbl[i].exmr,
            tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].ack);
      #2;
      chk12($sformatf("table%0d", i), dut_out(), tbl[i].exp);
      if (tbl[i].exp[10]) m_cnt = sat_inc(m_cnt);
      @(negedge clk);
      drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 1);
    end
    @(negedge clk);
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2;
    chk8("table_exc_count", bus.o_exc_count, 8'(m_cnt));

    // Store acknowledged three cycles after the first request.
    @(negedge clk);
    drive(0,1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2 chk12("store_w1", dut_out(), O_FRZ);
    @(negedge clk);
    #2 chk12("store_w2", dut_out(), O_FRZ);
    @(negedge clk);
    #2 chk12("store_w3", dut_out(), O_FRZ);
    @(negedge clk);
    bus.i_dmem_ack = 1'b1;
    #2 chk12("store_ack", dut_out(), O_REQ);
    @(negedge clk);
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2 chk12("store_after", dut_out(), O_IDLE);

    // Access that is never acknowledged.
    @(negedge clk);
    drive(1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2 chk12("noack_c1", dut_out(), O_FRZ);
`ifdef MEM_HAZARD_CTRL_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      #2 chk12($sformatf("noack_c%0d", c), dut_out(), O_FRZ);
    end
    @(negedge clk);
    #2 chk12("timeout_err", dut_out(), O_TO);
    m_cnt = sat_inc(m_cnt);
    @(negedge clk);
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2 chk12("timeout_run", dut_out(), O_IDLE);
    chk8("timeout_cnt", bus.o_exc_count, 8'(m_cnt));
`else
    for (int c = 2; c <= 1000; c++) @(negedge clk);
    #2 chk12("wait_1000", dut_out(), O_FRZ);
    @(negedge clk);
    bus.i_dmem_ack = 1'b1;
    #2 chk12("wait_1000_ack", dut_out(), O_REQ);
    @(negedge clk);
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
`endif

    // Reset in the middle of a wait drops the request at once.
    @(negedge clk);
    drive(1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    #2 chk12("rstwait_waiting", dut_out(), O_FRZ);
    #1 rst = 1'b1;
    #1 chk12("rstwait_req_drop", dut_out(), O_IDLE);
    chk8("rstwait_cnt", bus.o_exc_count, 8'd0);
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2 chk12("rstwait_run", dut_out(), O_IDLE);

    // 300 exceptions saturate the counter.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0);
      m_cnt = sat_inc(m_cnt);
    end
    @(negedge clk);
    drive(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0);
    #2 chk8("exc_saturate", bus.o_exc_count, 8'(m_cnt));

    // Randomised traffic against the reference model.
    m_wait = 1'b0;
    m_waited = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 3);
      #2;
      model_eval(e);
      chk12("rand_ctrl", dut_out(), e);
      chk8("rand_cnt", bus.o_exc_count, 8'(m_cnt));
      model_commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_hazard_ctrl.md
# mem_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It watches the MEM-stage fields held in the EX/MEM pipeline register and the EX-stage load destination. It generates hold and flush controls for the PC and all four pipeline registers, covering:
- data-memory request/acknowledge handshake with wait states,
- branch redirect,
- load-use interlock,
- arithmetic-overflow exception.

It is the only source of stall/flush for the datapath registers.

## Interface
Parameters:
- TIMEOUT, 255: max MEM_WAIT cycles before abort (only with timeout feature)
- CNT_W, 8: width of exception counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_MEM_ctrl_MemRead  in  1  EX/MEM output: load in MEM
- i_MEM_ctrl_MemWrite  in  1  EX/MEM output: store in MEM
- i_MEM_ctrl_Branch  in  1  EX/MEM output: branch in MEM
- i_MEM_data_Zero  in  1  EX/MEM output: branch condition
- i_MEM_data_Overflow  in  1  EX/MEM output: ALU overflow
- i_EX_ctrl_MemRead  in  1  ID/EX output: load in EX
- i_EX_data_RegAddrW  in  5  ID/EX load destination
- i_ID_data_RS, i_ID_data_RT  in  5 each  source registers of instruction in ID
- i_dmem_ack  in  1  data memory completes access this cycle
- o_dmem_req  out  1  data memory access request
- o_PC_hold, o_IF_ID_hold, o_ID_EX_hold, o_EX_MEM_hold  out  1 each  register keeps value
- o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_MEM_WB_flush  out  1 each  register loads bubble (all zeros)
- o_PCSrc  out  1  select branch target
- o_exc_take  out  1  redirect PC to exception vector
- o_dmem_err  out  1  access aborted by timeout
- o_exc_count  out  CNT_W  saturating count of exceptions taken

## Operation
- Definitions: access = (MemRead|MemWrite) & ~Overflow; taken = Branch & Zero.
- State machine: RUN and MEM_WAIT; registered; reset to RUN.
- Priority within a cycle, highest first: exception, branch, memory stall, load-use.
- RUN, Overflow=1:
  - o_exc_take=1;
  - flush IF/ID, ID/EX, EX/MEM and MEM/WB, so the faulting instruction does not write back;
  - o_dmem_req=0;
  - o_exc_count increments, saturating at all-ones.
- RUN, taken: o_PCSrc=1; flush IF/ID, ID/EX, EX/MEM.
- RUN, access:
  - o_dmem_req=1.
  - If i_dmem_ack=1 in the same cycle: zero-wait, no stall.
  - Otherwise: hold PC, IF/ID, ID/EX and EX/MEM; flush MEM/WB; next state MEM_WAIT.
- MEM_WAIT:
  - o_dmem_req=1;
  - holds asserted and MEM/WB flush asserted while i_dmem_ack=0;
  - in the ack cycle all holds and flushes deassert, the pipeline advances and the next state is RUN.
- Load-use: RUN, no higher-priority event, i_EX_ctrl_MemRead=1, i_EX_data_RegAddrW!=0, and RegAddrW equals RS or RT:
  - hold PC and IF/ID;
  - flush ID/EX.
- Hold and flush never both asserted on the same register. When both would apply, flush wins; only the exception/timeout case produces this.

## Timing
- All control outputs except o_exc_count and state are combinational from the inputs and the current state.
- While rst=1, all combinational outputs are forced to 0.
- Reset values: state RUN, wait counter 0, o_exc_count 0.
- Zero-wait access: no lost cycles. N-wait access (ack N cycles after first req): pipeline frozen for exactly N cycles.
- o_dmem_req stays 1 continuously from first assertion until the ack cycle inclusive, with no gaps.
- Reset mid-MEM_WAIT: state returns to RUN immediately and req drops asynchronously.
- o_exc_count updates at the clock edge ending the o_exc_take cycle.

## Configuration
Macro MEM_HAZARD_CTRL_TIMEOUT_EN enables the memory watchdog.

Defined:
- An 8-bit wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
- When it equals TIMEOUT with no ack, the cycle behaves as an exception: o_dmem_err=1, o_exc_take=1, all four flushes asserted, no holds, o_dmem_req=0, o_exc_count increments, next state RUN.
- An ack arriving in that same cycle wins: normal completion, no error.

Undefined:
- No counter; MEM_WAIT lasts indefinitely.
- o_dmem_err tied to 0.

## Test plan
- Load in MEM, ack same cycle -> o_dmem_req=1 for 1 cycle, no hold, state stays RUN.
- Store in MEM, ack after 3 cycles -> o_dmem_req=1 for 4 cycles; holds and MEM_WAIT flush for 3 cycles; advance on 4th.
- Branch=1, Zero=1 in MEM -> o_PCSrc=1 and flush IF/ID, ID/EX, EX/MEM for 1 cycle; Zero=0 -> no action.
- EX load to $5, ID RS=5 -> PC/IF_ID hold and ID_EX flush for 1 cycle; RegAddrW=0, RS=0 -> no stall.
- Overflow=1 together with MemWrite=1 -> o_dmem_req=0, o_exc_take=1, four flushes; 300 overflows -> o_exc_count=255.
- With macro, TIMEOUT=4, no ack -> o_dmem_err=1 on 5th req cycle, state RUN. Without macro -> still waiting after 1000 cycles. Assert rst mid-wait -> req=0 at once.
